tie_observe_shifter: RTL and testbench



---
 rtl/tie_observe_shifter.sv | 181 ++++++++++++++++++
 tb/tb_tie_observe_shifter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tie_observe_shifter.sv
// ---------------------------------------------------------------------------
// tie_observe_shifter
//
// Observes a vector of tie-cell outputs: on request it captures TIE_IN,
// compares it with the per-bit EXPECT pattern and updates a sticky MISMATCH
// flag. It then shifts the captured vector out on SO, LSB first, one beat
// per cycle.
//
// Optional feature, macro TIE_OBSERVE_PARITY_EN:
//   When defined, the even parity (XOR) of the captured vector is appended
//   as one extra SO beat after bit N_TIES-1.
//
// Ports:
//   CLK       in   clock, rising edge
//   RN        in   synchronous active-low reset
//   TIE_IN    in   [N_TIES] tie-cell outputs under observation
//   EXPECT    in   [N_TIES] expected level per bit (1 = tie-high)
//   START     in   start one capture/shift run (sampled in idle only)
//   CLR_ERR   in   clear sticky MISMATCH (a same-edge capture mismatch wins)
//   BUSY      out  run in progress (capture and shift cycles)
//   SO        out  serial data out
//   SO_VALID  out  SO carries a valid beat this cycle
//   DONE      out  one-cycle pulse at the end of a run
//   MISMATCH  out  sticky: some capture differed from EXPECT
//
// All outputs are registered; their next values are decoded from the next
// state so that they line up with the state they describe.
// ---------------------------------------------------------------------------
module tie_observe_shifter #(
    parameter int unsigned N_TIES = 8,
    parameter int unsigned CNT_W  = $clog2(N_TIES + 1)
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic [N_TIES-1:0] TIE_IN,
    input  logic [N_TIES-1:0] EXPECT,
    input  logic              START,
    input  logic              CLR_ERR,
    output logic              BUSY,
    output logic              SO,
    output logic              SO_VALID,
    output logic              DONE,
    output logic              MISMATCH
);

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StShift,
        StFin
    } state_e;

`ifdef TIE_OBSERVE_PARITY_EN
    localparam int unsigned NBeats = N_TIES + 1;
    // Beat index that carries the parity bit.
    localparam logic [CNT_W-1:0] ParBeat = CNT_W'(N_TIES);
`else
    localparam int unsigned NBeats = N_TIES;
`endif
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(NBeats - 1);

    state_e             state_q, state_d;
    logic [N_TIES-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mismatch_q, mismatch_d;
    logic               busy_q, busy_d;
    logic               so_q, so_d;
    logic               so_valid_q, so_valid_d;
    logic               done_q, done_d;
`ifdef TIE_OBSERVE_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StCapt;
            StCapt:  state_d = StShift;
            // cnt_q is the index of the beat currently on SO.
            StShift: if (cnt_q == LastBeat) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output next values
    // ------------------------------------------------------------------
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        mismatch_d = mismatch_q;
`ifdef TIE_OBSERVE_PARITY_EN
        parity_d   = parity_q;
`endif

        if (CLR_ERR) begin
            mismatch_d = 1'b0;
        end

        unique case (state_q)
            StCapt: begin
                shreg_d = TIE_IN;
                cnt_d   = '0;
                // Placed after the clear so a same-edge mismatch wins.
                if (TIE_IN != EXPECT) begin
                    mismatch_d = 1'b1;
                end
`ifdef TIE_OBSERVE_PARITY_EN
                parity_d = ^TIE_IN;
`endif
            end
            StShift: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase

        busy_d     = (state_d == StCapt) || (state_d == StShift);
        so_valid_d = (state_d == StShift);
        done_d     = (state_d == StFin);
        // The beat shown next cycle is bit 0 of the next shift register value.
        so_d       = so_valid_d & shreg_d[0];
`ifdef TIE_OBSERVE_PARITY_EN
        if (so_valid_d && (cnt_d == ParBeat)) begin
            so_d = parity_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RN) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef TIE_OBSERVE_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
`ifdef TIE_OBSERVE_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign BUSY     = busy_q;
    assign SO       = so_q;
    assign SO_VALID = so_valid_q;
    assign DONE     = done_q;
    assign MISMATCH = mismatch_q;

endmodule

// File: tb/tb_tie_observe_shifter.sv
// ---------------------------------------------------------------------------
// tb_tie_observe_shifter
//
// Directed bench for tie_observe_shifter (N_TIES = 8). Expected SO beats are
// pushed to a queue when a run is started and popped as SO_VALID beats
// appear. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tie_observe_shifter;

    localparam int unsigned N = 8;
`ifdef TIE_OBSERVE_PARITY_EN
    localparam int unsigned NBeats = N + 1;
`else
    localparam int unsigned NBeats = N;
`endif

    logic         CLK;
    logic         RN;
    logic [N-1:0] TIE_IN;
    logic [N-1:0] EXPECT;
    logic         START;
    logic         CLR_ERR;
    logic         BUSY;
    logic         SO;
    logic         SO_VALID;
    logic         DONE;
    logic         MISMATCH;

    int n_checks = 0;
    int n_fail   = 0;
    logic mism_exp = 1'b0;
    logic sb[$];

    tie_observe_shifter #(
        .N_TIES (N)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .TIE_IN   (TIE_IN),
        .EXPECT   (EXPECT),
        .START    (START),
        .CLR_ERR  (CLR_ERR),
        .BUSY     (BUSY),
        .SO       (SO),
        .SO_VALID (SO_VALID),
        .DONE     (DONE),
        .MISMATCH (MISMATCH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run. Cycle 1 is the capture cycle (first falling edge
    // after the edge that samples START); beat j must appear in cycle j+2
    // and DONE in cycle NBeats+2.
    task automatic run(input logic [N-1:0] tie, input logic [N-1:0] expv,
                       input bit clr_at_capt, input bit repulse);
        int cyc;
        int beats;
        int done_cyc;
        @(negedge CLK);
        TIE_IN = tie;
        EXPECT = expv;
        START  = 1'b1;
        for (int i = 0; i < int'(N); i++) sb.push_back(tie[i]);
`ifdef TIE_OBSERVE_PARITY_EN
        sb.push_back(^tie);
`endif
        if (tie != expv) mism_exp = 1'b1;
        else if (clr_at_capt) mism_exp = 1'b0;

        @(negedge CLK);
        START   = 1'b0;
        CLR_ERR = clr_at_capt;
        check("capt_busy", BUSY, 1);
        check("capt_so_valid", SO_VALID, 0);

        cyc      = 1;
        beats    = 0;
        done_cyc = 0;
        while (done_cyc == 0 && cyc < int'(N) + 12) begin
            @(negedge CLK);
            cyc++;
            CLR_ERR = 1'b0;
            // Inputs must be ignored outside the capture cycle.
            TIE_IN  = ~tie;
            EXPECT  = tie;
            START   = repulse && (cyc == 4);
            if (cyc == 2) check("mismatch_after_capt", MISMATCH, mism_exp);
            if (SO_VALID) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("so_beat", SO, sb.pop_front());
                    check("beat_cycle", cyc, beats + 2);
                end
                beats++;
            end
            if (DONE) done_cyc = cyc;
        end
        START = 1'b0;
        check("beat_count", beats, NBeats);
        check("done_cycle", done_cyc, NBeats + 2);
        check("fin_busy", BUSY, 0);
        check("fin_so", SO, 0);
        check("mismatch_end", MISMATCH, mism_exp);
        check("sb_empty", sb.size(), 0);
        @(negedge CLK);
        check("done_single_pulse", DONE, 0);
        check("idle_busy", BUSY, 0);
        check("idle_so_valid", SO_VALID, 0);
    endtask

    initial begin
        int   beats;
        logic seen;
        RN      = 1'b0;
        TIE_IN  = '0;
        EXPECT  = '0;
        START   = 1'b0;
        CLR_ERR = 1'b0;

        // Reset held two cycles.
        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_so", SO, 0);
        check("rst_so_valid", SO_VALID, 0);
        check("rst_done", DONE, 0);
        check("rst_mismatch", MISMATCH, 0);
        RN = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", BUSY, 0);

        // Clean run, then mismatch, then clean run with sticky flag kept.
        run(8'hA5, 8'hA5, 1'b0, 1'b0);
        run(8'hA4, 8'hA5, 1'b0, 1'b0);
        run(8'hA5, 8'hA5, 1'b0, 1'b0);

        // CLR_ERR pulse in idle.
        @(negedge CLK);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR  = 1'b0;
        mism_exp = 1'b0;
        check("clr_err_idle", MISMATCH, 0);

        // Clear colliding with a mismatching capture; START re-pulsed mid-shift.
        run(8'hA4, 8'hA5, 1'b1, 1'b1);
        @(negedge CLK);
        check("repulse_ignored_busy", BUSY, 0);

        // Clear with a clean capture on the same edge.
        run(8'h07, 8'h07, 1'b1, 1'b0);

        // Reset in the middle of a run.
        @(negedge CLK);
        TIE_IN = 8'hA4;
        EXPECT = 8'hA5;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        beats = 0;
        for (int i = 0; i < 20 && beats < 4; i++) begin
            @(negedge CLK);
            if (SO_VALID) beats++;
        end
        check("rst_mid_reach_beat", beats, 4);
        check("rst_mid_mismatch_before", MISMATCH, 1);
        RN = 1'b0;
        @(negedge CLK);
        RN = 1'b1;
        mism_exp = 1'b0;
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_so", SO, 0);
        check("rst_mid_so_valid", SO_VALID, 0);
        check("rst_mid_done", DONE, 0);
        check("rst_mid_mismatch", MISMATCH, 0);
        seen = 1'b0;
        for (int i = 0; i < int'(N) + 4; i++) begin
            @(negedge CLK);
            seen = seen | DONE | BUSY | SO_VALID;
        end
        check("rst_mid_stays_idle", seen, 0);

        // Fresh runs after the abort.
        run(8'h3C, 8'h3C, 1'b0, 1'b0);
        run(N'($urandom), 8'h5A, 1'b0, 1'b0);
        run(8'hFF, 8'hFF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
